// File: rtl/ysyx_24110015_mdu_if.sv
// Request/response bundle of the RV32M multiply/divide unit.
// The master side issues operations; the slave side (the MDU) returns tagged results.
interface ysyx_24110015_mdu_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       func3;
  logic [XLEN-1:0]  src1;
  logic [XLEN-1:0]  src2;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output in_valid, func3, src1, src2, tag_i, out_ready,
    input  in_ready, out_valid, result, tag_o
  );

  modport slave (
    input  in_valid, func3, src1, src2, tag_i, out_ready,
    output in_ready, out_valid, result, tag_o
  );
endinterface

// File: rtl/ysyx_24110015_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define YSYX_24110015_MDU_FAST_MUL_EN to make all multiplies single-cycle (divide unchanged).
module ysyx_24110015_mdu #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  output logic               busy,
  ysyx_24110015_mdu_if.slave bus
);

  localparam int unsigned W2    = 2 * XLEN;
  localparam int unsigned CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [XLEN-1:0]  opb_q, opb_d;
  logic [2:0]       f3_q, f3_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic             accept_c, sgn1_c, sgn2_c, neg1_c, neg2_c, div0_c, ovf_c;
  logic [XLEN-1:0]  mag1_c, mag2_c, special_c;

  // Request decode: operand signedness, magnitudes and the two shortcut cases
  always_comb begin
    accept_c  = bus.in_valid & in_ready_q & ~flush;
    sgn1_c    = bus.func3[2] ? ~bus.func3[0] : (bus.func3[1:0] != 2'b11);
    sgn2_c    = bus.func3[2] ? ~bus.func3[0] : ~bus.func3[1];
    neg1_c    = sgn1_c & bus.src1[XLEN-1];
    neg2_c    = sgn2_c & bus.src2[XLEN-1];
    mag1_c    = neg1_c ? -bus.src1 : bus.src1;
    mag2_c    = neg2_c ? -bus.src2 : bus.src2;
    div0_c    = bus.func3[2] & (bus.src2 == '0);
    ovf_c     = bus.func3[2] & ~bus.func3[0]
              & (bus.src1 == {1'b1, {(XLEN-1){1'b0}}}) & (bus.src2 == '1);
    if (div0_c) begin
      special_c = bus.func3[1] ? bus.src1 : '1;
    end else begin
      special_c = bus.func3[1] ? '0 : bus.src1;
    end
  end

  logic [XLEN:0]   mul_sum_c, rem_sh_c, rem_sub_c;
  logic [W2-1:0]   step_c, full_c;
  logic [XLEN-1:0] quo_c, rem_c, final_c;

  // One iteration; acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum_c = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    rem_sh_c  = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
    rem_sub_c = rem_sh_c - {1'b0, opb_q};
    if (f3_q[2]) begin
      // no borrow out of the subtraction means the divisor fits
      if (!rem_sub_c[XLEN]) begin
        step_c = {rem_sub_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        step_c = {rem_sh_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step_c = {mul_sum_c, acc_q[XLEN-1:1]};
    end
    full_c = neg_quo_q ? -step_c : step_c;
    quo_c  = neg_quo_q ? -step_c[XLEN-1:0] : step_c[XLEN-1:0];
    rem_c  = neg_rem_q ? -step_c[W2-1:XLEN] : step_c[W2-1:XLEN];
    case (f3_q)
      3'b000:                 final_c = full_c[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_c = full_c[W2-1:XLEN];
      3'b100, 3'b101:         final_c = quo_c;
      default:                final_c = rem_c;
    endcase
  end

`ifdef YSYX_24110015_MDU_FAST_MUL_EN
  logic [W2-1:0]   fast_mag_c, fast_full_c;
  logic [XLEN-1:0] fast_res_c;

  // Single-cycle signed/unsigned multiply on the incoming operands
  always_comb begin
    fast_mag_c  = W2'(mag1_c) * W2'(mag2_c);
    fast_full_c = (neg1_c ^ neg2_c) ? -fast_mag_c : fast_mag_c;
    fast_res_c  = (bus.func3[1:0] == 2'b00) ? fast_full_c[XLEN-1:0] : fast_full_c[W2-1:XLEN];
  end
`endif

  // Control FSM and datapath register updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    f3_d        = f3_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    tag_d       = tag_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            f3_d      = bus.func3;
            tag_d     = bus.tag_i;
            acc_d     = {{XLEN{1'b0}}, mag1_c};
            opb_d     = mag2_c;
            neg_quo_d = neg1_c ^ neg2_c;
            neg_rem_d = neg1_c;
            if (div0_c || ovf_c) begin
              result_d    = special_c;
              out_valid_d = 1'b1;
              state_d     = DONE;
`ifdef YSYX_24110015_MDU_FAST_MUL_EN
            end else if (!bus.func3[2]) begin
              result_d    = fast_res_c;
              out_valid_d = 1'b1;
              state_d     = DONE;
`endif
            end else begin
              cnt_d   = CNT_W'(XLEN);
              state_d = CALC;
            end
          end
        end
        CALC: begin
          acc_d = step_c;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          if (cnt_q == CNT_W'(1)) begin
            result_d    = final_c;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opb_q       <= '0;
      f3_q        <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      tag_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      f3_q        <= f3_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      tag_q       <= tag_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.tag_o     = tag_q;
  assign busy          = busy_q;

endmodule

// File: doc/ysyx_24110015_mdu.md
YSYX_24110015_MDU -- requirements
Module: ysyx_24110015_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter TAG_W, default 5, width of writeback register tag carried through.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  in  1  request valid.
REQ-006 SHALL have port in_ready  out  1  unit can accept request.
REQ-007 SHALL have port func3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have ports src1, src2  in  XLEN  operands (rs1, rs2).
REQ-009 SHALL have port tag_i  in  TAG_W  destination register; tag_o  out  TAG_W  registered copy.
REQ-010 SHALL have port flush  in  1  abort in-flight op.
REQ-011 SHALL have port out_valid  out  1  result valid; out_ready  in  1  consumer accepts.
REQ-012 SHALL have port result  out  XLEN  op result; busy  out  1  state != IDLE.

Function
REQ-013 SHALL implement FSM IDLE, CALC, DONE; in_ready = (state==IDLE).
REQ-014 Accept = in_valid & in_ready; on accept SHALL latch func3, tag_i, operand magnitudes and sign flags.
REQ-015 IDLE->CALC on accept for normal ops; CALC SHALL run exactly XLEN cycles (down-counter loaded XLEN, decrements each CALC cycle), then ->DONE.
REQ-016 Multiply SHALL be iterative shift-add on magnitudes into 2*XLEN product; signed correction applied on CALC->DONE; MUL returns low XLEN bits, MULH/MULHSU/MULHU high XLEN bits; MULHSU treats src1 signed, src2 unsigned.
REQ-017 Divide SHALL be restoring radix-2, one quotient bit per cycle on magnitudes; quotient sign = sign1^sign2, remainder sign = sign of dividend (signed ops only).
REQ-018 Divide by zero SHALL go IDLE->DONE directly: DIV/DIVU quotient all ones, REM/REMU remainder = src1.
REQ-019 Signed overflow (src1 = most negative, src2 = -1) on DIV/REM SHALL go IDLE->DONE directly: DIV = src1, REM = 0.
REQ-020 Normal op: out_valid first high XLEN+1 rising edges after accept edge; special case (REQ-018/019): 1 edge after accept.
REQ-021 DONE: out_valid=1, result and tag_o stable until out_valid & out_ready; then ->IDLE next edge; no new accept in same cycle as handoff.
REQ-022 flush SHALL force ->IDLE on next edge from any state, clear out_valid, discard result; flush has priority over accept and handoff; accept SHALL NOT occur while flush=1.
REQ-023 result and tag_o SHALL be registered (no combinational path from inputs).
REQ-024 Counter SHALL be width clog2(XLEN+1); no wrap past zero.

Reset
REQ-025 rst low SHALL asynchronously force state=IDLE, counter=0, out_valid=0, result=0, tag_o=0, busy=0; in_ready=1 after release.
REQ-026 Reset asserted mid-CALC or in DONE SHALL drop the op with no output.

Configuration
REQ-027 Macro YSYX_24110015_MDU_FAST_MUL_EN: when defined, all four multiply ops SHALL use a single-cycle array multiply, going IDLE->DONE with out_valid 1 edge after accept; divide unchanged.
REQ-028 Without YSYX_24110015_MDU_FAST_MUL_EN, multiply SHALL be iterative per REQ-015/016/020.

Verification
REQ-029 XLEN=32, no macro: MUL src1=7, src2=-3 (0xFFFFFFFD), out_ready=1 -> out_valid after 33 edges, result=0xFFFFFFEB.
REQ-030 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU -1 x 2 -> 0xFFFFFFFF.
REQ-031 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF after 1 edge; DIV 0x80000000/-1 -> 0x80000000 after 1 edge, REM -> 0.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> result/tag_o stable, in_ready=0; out_ready=1 -> handoff, in_ready=1 next edge.
REQ-033 flush at CALC cycle 10 -> IDLE next edge, out_valid never asserted, next op (DIVU 9/3=3) correct; rst low mid-CALC -> all outputs reset immediately.
REQ-034 With YSYX_24110015_MDU_FAST_MUL_EN: MUL 6x7 -> result 42 with out_valid 1 edge after accept; DIVU 42/6 still XLEN+1 edges -> 7.
